// File: rtl/ureg_bank.sv
// ureg_bank: multi-channel microcode scratch-register bank.
//
// A single-port DEPTH x DW array is shared by NCH requesters through a
// round-robin arbiter. One access is granted per cycle. A granted channel gets a
// one-cycle req_ready pulse, and rsp_rdata holds the entry contents as they were
// before the access. After reset, a clear sequencer zeroes every entry. No
// requests are granted until that sequence finishes.
//
// Optional feature: define UREG_ZERO_REG_EN to hardwire entry 0 to zero. Reads
// of address 0 then return 0, and writes to address 0 are acknowledged but
// dropped.
//
// Ports:
//   clk        clock
//   rstn       synchronous active-low reset
//   req_valid  per-channel request, held until req_ready
//   req_addr   per-channel address, channel k at [k*AW +: AW]
//   req_write  per-channel 1 = write, 0 = read
//   req_wdata  per-channel write data, channel k at [k*DW +: DW]
//   req_wstrb  per-channel byte enables for writes
//   req_ready  one-cycle completion pulse per channel
//   rsp_rdata  per-channel read data (pre-access contents), held until next grant
//   busy       high while the clear sequencer runs
module ureg_bank #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 8,
    parameter int unsigned NCH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCH-1:0]        req_valid,
    input  logic [NCH*AW-1:0]     req_addr,
    input  logic [NCH-1:0]        req_write,
    input  logic [NCH*DW-1:0]     req_wdata,
    input  logic [NCH*DW/8-1:0]   req_wstrb,
    output logic [NCH-1:0]        req_ready,
    output logic [NCH*DW-1:0]     rsp_rdata,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [PW-1:0]   ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  gnt;
    logic            gnt_any;
    logic [PW-1:0]   ptr_nxt;
    logic [AW-1:0]   g_addr;
    logic            g_write;
    logic [DW-1:0]   g_wdata;
    logic [BW-1:0]   g_wstrb;
    logic [DW-1:0]   old_data;
    logic [DW-1:0]   new_data;
    logic            g_store;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;

    // Round-robin arbiter. The first pass scans channels at or above the
    // pointer, and the second pass wraps around to the lower channels.
    // A channel whose ready is high this cycle is not eligible.
    always_comb begin
        elig    = req_valid & ~req_ready;
        gnt     = '0;
        gnt_any = 1'b0;
        ptr_nxt = ptr;
        if (state == SERVE) begin
            for (int k = 0; k < int'(NCH); k++) begin
                if (!gnt_any && elig[k] && (k >= int'(ptr))) begin
                    gnt[k]  = 1'b1;
                    gnt_any = 1'b1;
                end
            end
            for (int k = 0; k < int'(NCH); k++) begin
                if (!gnt_any && elig[k]) begin
                    gnt[k]  = 1'b1;
                    gnt_any = 1'b1;
                end
            end
        end
        for (int k = 0; k < int'(NCH); k++) begin
            if (gnt[k]) begin
                ptr_nxt = (k == int'(NCH) - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    // Multiplex the granted channel's request fields.
    always_comb begin
        g_addr  = '0;
        g_write = 1'b0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (gnt[k]) begin
                g_addr  = req_addr[k*AW +: AW];
                g_write = req_write[k];
                g_wdata = req_wdata[k*DW +: DW];
                g_wstrb = req_wstrb[k*BW +: BW];
            end
        end
    end

    // Read-before-write data path with byte-strobe merge.
    always_comb begin
        old_data = mem[g_addr];
        g_store  = g_write;
`ifdef UREG_ZERO_REG_EN
        if (g_addr == '0) begin
            old_data = '0;
            g_store  = 1'b0;
        end
`endif
        for (int b = 0; b < int'(BW); b++) begin
            new_data[b*8 +: 8] = g_wstrb[b] ? g_wdata[b*8 +: 8] : old_data[b*8 +: 8];
        end
        mem_we    = 1'b0;
        mem_waddr = g_addr;
        mem_wdata = new_data;
        if (state == CLEAR) begin
            mem_we    = rstn;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (gnt_any && g_store) begin
            mem_we    = 1'b1;
        end
    end

    // Storage array, no reset: contents are established by the clear sequencer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: clear sequencing, pointer update and registered responses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            ptr       <= '0;
            req_ready <= '0;
            rsp_rdata <= '0;
            busy      <= 1'b1;
        end else begin
            req_ready <= gnt;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= SERVE;
                        busy  <= 1'b0;
                    end
                end
                SERVE: begin
                    if (gnt_any) begin
                        ptr <= ptr_nxt;
                        for (int k = 0; k < int'(NCH); k++) begin
                            if (gnt[k]) begin
                                rsp_rdata[k*DW +: DW] <= old_data;
                            end
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ureg_bank.sv
// Directed testbench for ureg_bank (DW=32, AW=8, NCH=2). Expected responses are
// queued in grant order when requests are driven. A monitor pops and checks one
// entry on every req_ready pulse.
module tb_ureg_bank;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NCH = 2;

`ifdef UREG_ZERO_REG_EN
    localparam logic [31:0] ZERO_RD = 32'h0000_0000;
`else
    localparam logic [31:0] ZERO_RD = 32'h1234_5678;
`endif

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NCH-1:0]      req_valid = '0;
    logic [NCH*AW-1:0]   req_addr = '0;
    logic [NCH-1:0]      req_write = '0;
    logic [NCH*DW-1:0]   req_wdata = '0;
    logic [NCH*DW/8-1:0] req_wstrb = '0;
    logic [NCH-1:0]      req_ready;
    logic [NCH*DW-1:0]   rsp_rdata;
    logic                busy;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    ureg_bank #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: each ready pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rstn && req_ready != '0) begin
            n_assert++;
            assert ($countones(req_ready) == 1) else begin
                n_fail++;
                $error("FAIL one_grant observed=%b required=one-hot", req_ready);
            end
            for (int k = 0; k < NCH; k++) begin
                if (req_ready[k]) begin
                    n_assert++;
                    assert (sb.size() > 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_ready ch=%0d observed=1 required=0", k);
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        n_assert++;
                        assert (k == e.ch) else begin
                            n_fail++;
                            $error("FAIL grant_order observed=ch%0d required=ch%0d", k, e.ch);
                        end
                        n_assert++;
                        assert (rsp_rdata[k*DW +: DW] === e.data) else begin
                            n_fail++;
                            $error("FAIL rdata ch=%0d observed=%h required=%h",
                                   k, rsp_rdata[k*DW +: DW], e.data);
                        end
                    end
                end
            end
        end
    end

    // Single-channel access; returns after the ready pulse is seen.
    task automatic req1(input int ch, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rd);
        bit done;
        sb.push_back('{ch, exp_rd});
        req_addr[ch*AW +: AW]  = addr;
        req_write[ch]          = wr;
        req_wdata[ch*DW +: DW] = wd;
        req_wstrb[ch*4 +: 4]   = ws;
        req_valid[ch]          = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(posedge clk); #1;
            if (req_ready[ch]) done = 1'b1;
        end
        req_valid[ch] = 1'b0;
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL req1_timeout ch=%0d observed=no_ready required=ready", ch);
        end
    endtask

    // Both channels request the same address together; ch0 is expected first.
    task automatic req2(input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [31:0] e0, input logic [31:0] e1);
        bit d0, d1;
        int t0, t1;
        sb.push_back('{0, e0});
        sb.push_back('{1, e1});
        req_addr  = {addr, addr};
        req_write = {wr, wr};
        req_wdata = {wd1, wd0};
        req_wstrb = 8'hFF;
        req_valid = 2'b11;
        d0 = 1'b0; d1 = 1'b0; t0 = 0; t1 = 0;
        for (int t = 0; t < 20 && !(d0 && d1); t++) begin
            @(posedge clk); #1;
            if (!d0 && req_ready[0]) begin d0 = 1'b1; t0 = cyc; req_valid[0] = 1'b0; end
            if (!d1 && req_ready[1]) begin d1 = 1'b1; t1 = cyc; req_valid[1] = 1'b0; end
        end
        req_valid = 2'b00;
        n_assert++;
        assert (d0 && d1) else begin
            n_fail++;
            $error("FAIL req2_timeout observed=%b%b required=11", d1, d0);
        end
        n_assert++;
        assert (t1 == t0 + 1) else begin
            n_fail++;
            $error("FAIL ch1_one_after_ch0 observed=%0d required=%0d", t1, t0 + 1);
        end
    endtask

    initial begin
        int  n;
        bit  saw_rdy;
        int  pulses;
        int  used;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        assert (busy === 1'b1) else begin n_fail++; $error("FAIL reset_busy observed=%b required=1", busy); end
        n_assert++;
        assert (req_ready === 2'b00) else begin n_fail++; $error("FAIL reset_ready observed=%b required=00", req_ready); end
        n_assert++;
        assert (rsp_rdata === 64'h0) else begin n_fail++; $error("FAIL reset_rdata observed=%h required=0", rsp_rdata); end

        // Start clearing, then reset at clear cycle 100.
        @(negedge clk) rstn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        n_assert++;
        assert (busy === 1'b1) else begin n_fail++; $error("FAIL busy_mid_clear observed=%b required=1", busy); end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        // Hold a read of 0x7F pending across the whole clear.
        sb.push_back('{0, 32'h0});
        req_addr[0 +: AW] = 8'h7F;
        req_write[0]      = 1'b0;
        req_valid[0]      = 1'b1;
        n = 0;
        saw_rdy = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            n++;
            if (req_ready != '0) saw_rdy = 1'b1;
            if (!busy) break;
        end
        n_assert++;
        assert (n == 256) else begin n_fail++; $error("FAIL busy_cycles observed=%0d required=256", n); end
        n_assert++;
        assert (!saw_rdy) else begin n_fail++; $error("FAIL ready_during_clear observed=1 required=0"); end
        @(posedge clk); #1;
        n_assert++;
        assert (req_ready === 2'b01) else begin n_fail++; $error("FAIL first_grant observed=%b required=01", req_ready); end
        req_valid[0] = 1'b0;

        // Cleared entries at the boundaries.
        req1(0, 1'b0, 8'h00, 32'h0, 4'h0, 32'h0000_0000);
        req1(0, 1'b0, 8'hFF, 32'h0, 4'h0, 32'h0000_0000);

        // Byte strobes and read-before-write.
        req1(0, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000);
        req1(0, 1'b1, 8'h05, 32'h1122_3344, 4'b0101, 32'hDEAD_BEEF);
        req1(0, 1'b0, 8'h05, 32'h0, 4'h0, 32'hDE22_BE44);

        // Zero register, or ordinary storage in the default build.
        req1(0, 1'b1, 8'h00, 32'h1234_5678, 4'hF, 32'h0000_0000);
        req1(0, 1'b0, 8'h00, 32'h0, 4'h0, ZERO_RD);

        // A ch1 grant returns the pointer to ch0.
        req1(1, 1'b0, 8'h05, 32'h0, 4'h0, 32'hDE22_BE44);

        // Contention on address 9: ch0 writes first, ch1 sees ch0's write.
        req2(1'b1, 8'h09, 32'hAAAA_0000, 32'h0000_BBBB, 32'h0000_0000, 32'hAAAA_0000);
        // The pointer is back at ch0, so ch0 again wins; both see ch1's write.
        req2(1'b0, 8'h09, 32'h0, 32'h0, 32'h0000_BBBB, 32'h0000_BBBB);

        // Fairness: both channels request back to back, and grants alternate.
        for (int i = 0; i < 8; i++) sb.push_back('{i % 2, 32'h0000_BBBB});
        req_addr  = {8'h09, 8'h09};
        req_write = 2'b00;
        req_valid = 2'b11;
        pulses = 0;
        used   = 0;
        for (int t = 0; t < 40 && pulses < 8; t++) begin
            @(posedge clk); #1;
            used++;
            if (req_ready != '0) pulses++;
        end
        req_valid = 2'b00;
        n_assert++;
        assert (pulses == 8) else begin n_fail++; $error("FAIL rr_pulses observed=%0d required=8", pulses); end
        n_assert++;
        assert (used == 8) else begin n_fail++; $error("FAIL rr_throughput observed=%0d required=8", used); end

        repeat (4) @(posedge clk);
        #1;
        n_assert++;
        assert (sb.size() == 0) else begin n_fail++; $error("FAIL scoreboard_drained observed=%0d required=0", sb.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
